// File: rtl/slp_train_seq.sv
// slp_train_seq: buffers labelled samples and replays them epoch by epoch into a perceptron,
// counting mispredictions; optional early stop on a zero-error epoch via SLP_SEQ_EARLY_STOP_EN.
module slp_train_seq #(
    parameter int IN      = 8,
    parameter int I_PREC  = 16,
    parameter int O_PREC  = 16,
    parameter int DEPTH   = 16,
    parameter int EPOCH_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [IN-1:0][I_PREC-1:0]     ld_in,
    input  logic [O_PREC-1:0]             ld_train,
    input  logic                          clr,
    input  logic                          start,
    input  logic [EPOCH_W-1:0]            max_epoch,
    output logic                          busy,
    output logic                          done,
    output logic                          converged,
    output logic [EPOCH_W-1:0]            epoch_cnt,
    output logic [$clog2(DEPTH+1)-1:0]    err_cnt,
    output logic [IN-1:0][I_PREC-1:0]     slp_in,
    output logic [O_PREC-1:0]             slp_train,
    output logic                          slp_t_en,
    input  logic [O_PREC-1:0]             slp_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d, err_q, err_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [EPOCH_W-1:0]   ep_q, ep_d, max_q, max_d;
    logic                 done_q, done_d, conv_q, conv_d, wr;
    logic [IN-1:0][I_PREC-1:0] mem_in [DEPTH];
    logic [O_PREC-1:0]         mem_tr [DEPTH];

    assign slp_in    = mem_in[idx_q];
    assign slp_train = mem_tr[idx_q];
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign converged = conv_q;
    assign epoch_cnt = ep_q;
    assign err_cnt   = err_q;

    // sample storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_in[count_q[IW-1:0]] <= ld_in;
            mem_tr[count_q[IW-1:0]] <= ld_train;
        end
    end

    // state and run bookkeeping registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            ep_q    <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ep_q    <= ep_d;
            max_q   <= max_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
        end
    end

    // next state, loading, replay and epoch accounting
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ep_d     = ep_q;
        max_d    = max_q;
        done_d   = done_q;
        conv_d   = conv_q;
        wr       = 1'b0;
        ld_ready = 1'b0;
        slp_t_en = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = count_q != CW'(DEPTH);
                wr       = ld_valid && ld_ready && !clr;
                if (clr) begin
                    count_d = '0;
                end else begin
                    if (wr) count_d = count_q + 1'b1;
                    if (start && count_q != '0) begin
                        state_d = RUN;
                        done_d  = 1'b0;
                        conv_d  = 1'b0;
                        ep_d    = '0;
                        err_d   = '0;
                        idx_d   = '0;
                        max_d   = (max_epoch == '0) ? EPOCH_W'(1) : max_epoch;
                    end
                end
            end
            RUN: begin
                slp_t_en = 1'b1;
                if (slp_out != slp_train) err_d = err_q + 1'b1;
                idx_d = idx_q + 1'b1;
                if (CW'(idx_q) == count_q - 1'b1) state_d = CHECK;
            end
            CHECK: begin
                ep_d  = ep_q + 1'b1;
                idx_d = '0;
`ifdef SLP_SEQ_EARLY_STOP_EN
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else
`endif
                if ({1'b0, ep_q} + 1'b1 >= {1'b0, max_q}) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_slp_train_seq.sv
// tb_slp_train_seq: directed and randomized checks of slp_train_seq against a sample-queue model
module tb_slp_train_seq;
    localparam int IN = 8, IP = 16, OP = 16, DEPTH = 16, EW = 8, CW = $clog2(DEPTH + 1);

    logic clk = 0, reset_ = 1, ld_valid = 0, clr = 0, start = 0, flip = 0;
    logic [IN-1:0][IP-1:0] ld_in = '0;
    logic [OP-1:0] ld_train = '0;
    logic [EW-1:0] max_epoch = '0;
    logic ld_ready, busy, done, converged, slp_t_en;
    logic [EW-1:0] epoch_cnt;
    logic [CW-1:0] err_cnt;
    logic [IN-1:0][IP-1:0] slp_in;
    logic [OP-1:0] slp_train, slp_out;

    int total = 0, bad = 0;
    bit es;
    bit rnd [8][DEPTH];
    logic [IN-1:0][IP-1:0] m_in [$];
    logic [OP-1:0] m_tr [$];

    slp_train_seq dut (
        .clk(clk), .reset_(reset_), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_in(ld_in),
        .ld_train(ld_train), .clr(clr), .start(start), .max_epoch(max_epoch), .busy(busy),
        .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt),
        .slp_in(slp_in), .slp_train(slp_train), .slp_t_en(slp_t_en), .slp_out(slp_out)
    );

    // perceptron stub: predicts the label unless told to miss
    assign slp_out = flip ? ~slp_train : slp_train;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit miss(input int mode, input int e, input int i);
        return mode == 0 ? 1'b1 : mode == 1 ? (e == 0) : rnd[e][i];
    endfunction

    task automatic rand_sample();
        for (int k = 0; k < IN; k++) ld_in[k] = IP'($urandom);
        ld_train = OP'($urandom);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            rand_sample();
            chk("ld_ready", ld_ready, m_in.size() < DEPTH);
            ld_valid = 1;
            if (m_in.size() < DEPTH) begin
                m_in.push_back(ld_in);
                m_tr.push_back(ld_train);
            end
            @(negedge clk);
        end
        ld_valid = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        @(negedge clk);
        clr = 0;
        m_in.delete();
        m_tr.delete();
    endtask

    task automatic run(input int maxe, input int mode, input bit wr);
        int n, eff, ep, errs;
        if (wr) begin
            rand_sample();
            ld_valid = 1;
            if (m_in.size() < DEPTH) begin
                m_in.push_back(ld_in);
                m_tr.push_back(ld_train);
            end
        end
        start = 1;
        max_epoch = EW'(maxe);
        @(negedge clk);
        start = 0;
        ld_valid = 0;
        max_epoch = EW'($urandom);
        n = m_in.size();
        eff = maxe == 0 ? 1 : maxe;
        ep = 0;
        errs = 0;
        for (int e = 0; e < eff; e++) begin
            errs = 0;
            for (int i = 0; i < n; i++) begin
                chk("run_busy", busy, 1);
                chk("run_t_en", slp_t_en, 1);
                chk("run_in", slp_in, m_in[i]);
                chk("run_train", slp_train, m_tr[i]);
                flip = miss(mode, e, i);
                errs += int'(flip);
                @(negedge clk);
            end
            flip = 0;
            chk("chk_busy", busy, 1);
            chk("chk_t_en", slp_t_en, 0);
            @(negedge clk);
            ep = e + 1;
            if (es && errs == 0) break;
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_epoch", epoch_cnt, ep);
        chk("end_err", err_cnt, errs);
        chk("end_conv", converged, es && errs == 0);
        chk("end_ready", ld_ready, n < DEPTH);
    endtask

    initial begin
`ifdef SLP_SEQ_EARLY_STOP_EN
        es = 1;
`else
        es = 0;
`endif
        foreach (rnd[e, i]) rnd[e][i] = 1'($urandom_range(0, 1));
        #2 reset_ = 0;
        #2;
        chk("rst_ready", ld_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", converged, 0);
        chk("rst_epoch", epoch_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_t_en", slp_t_en, 0);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1;
        @(negedge clk);

        load(4);
        run(3, 0, 0);
        run(5, 1, 0);

        do_clr();
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) begin
            chk("empty_busy", busy, 0);
            @(negedge clk);
        end

        load(2);
        run(0, 0, 0);

        clr = 1;
        start = 1;
        @(negedge clk);
        clr = 0;
        start = 0;
        m_in.delete();
        m_tr.delete();
        chk("clrstart_busy", busy, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("clrstart_again", busy, 0);

        load(3);
        run(2, 2, 1);

        do_clr();
        load(DEPTH);
        load(1);
        run(2, 2, 0);

        do_clr();
        load(5);
        start = 1;
        max_epoch = 3;
        @(negedge clk);
        start = 0;
        flip = 1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_t_en", slp_t_en, 1);
        chk("mid_train", slp_train, m_tr[2]);
        #2 reset_ = 0;
        #1;
        chk("arst_t_en", slp_t_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", ld_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_epoch", epoch_cnt, 0);
        chk("arst_err", err_cnt, 0);
        #1 reset_ = 1;
        flip = 0;
        m_in.delete();
        m_tr.delete();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("arst_start_ign", busy, 0);

        for (int r = 0; r < 4; r++) begin
            do_clr();
            load($urandom_range(1, DEPTH));
            run($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/slp_train_seq.md
# slp_train_seq

Training sequencer that sits directly upstream of the single-layer perceptron. It buffers a small labelled data set, then replays it epoch by epoch into the perceptron's `in`/`train`/`t_en` ports while counting mispredictions from the perceptron's `out`. It stops after a programmed number of epochs, or earlier on a zero-error epoch when early stop is compiled in.

## Interface
Parameters:
- `IN`, 8, number of perceptron inputs per sample.
- `I_PREC`, 16, input element width; must equal the perceptron's `I_PREC`.
- `O_PREC`, 16, label/output width; must equal the perceptron's `O_PREC`.
- `DEPTH`, 16, sample buffer capacity; power of two, at least 2.
- `EPOCH_W`, 8, epoch counter width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset_`  in  1  asynchronous active-low reset.
- `ld_valid`  in  1  sample write request.
- `ld_ready`  out  1  buffer can accept a sample.
- `ld_in`  in  IN×I_PREC  sample inputs (packed `[IN-1:0][I_PREC-1:0]`).
- `ld_train`  in  O_PREC  sample label.
- `clr`  in  1  empty the buffer (IDLE only).
- `start`  in  1  begin training run (IDLE only).
- `max_epoch`  in  EPOCH_W  epochs to run; 0 is treated as 1.
- `busy`  out  1  run in progress.
- `done`  out  1  sticky: last run finished.
- `converged`  out  1  sticky: last run ended on a zero-error epoch.
- `epoch_cnt`  out  EPOCH_W  epochs completed in the current or last run.
- `err_cnt`  out  $clog2(DEPTH+1)  mispredictions in the current or last epoch.
- `slp_in`  out  IN×I_PREC  to perceptron `in`.
- `slp_train`  out  O_PREC  to perceptron `train`.
- `slp_t_en`  out  1  to perceptron `t_en`.
- `slp_out`  in  O_PREC  from perceptron `out`.

## Operation
- FSM states: IDLE, RUN, CHECK. Reset enters IDLE.
- Buffer: `count` holds the samples stored (0..DEPTH), and `idx` is the replay pointer.
- IDLE:
  - `ld_ready = (count < DEPTH)`.
  - A write occurs when `ld_valid && ld_ready`: the sample is stored at `count`, then `count++`.
  - `clr` sets `count = 0` and takes priority over a same-cycle write and over `start`.
  - `start` with `count != 0` does the following, then goes to RUN: clears `done`, `converged`, `epoch_cnt`, `err_cnt` and sets `idx = 0`.
  - `start` with `count == 0` is ignored.
  - A same-cycle accepted write is stored, and the run includes it.
- RUN:
  - `slp_t_en = 1`; `slp_in`/`slp_train` equal the buffer entry at `idx` (combinational read).
  - Each cycle `err_cnt` increments if `slp_out != slp_train`; the comparison uses pre-update weights.
  - `idx++`. On `idx == count-1`, go to CHECK.
  - `ld_ready = 0`; `clr` and `start` are ignored.
- CHECK:
  - `slp_t_en = 0`. Set `epoch_cnt++` and `idx = 0`.
  - If early stop is active and `err_cnt == 0`: set `converged`, set `done`, go to IDLE.
  - Else if `epoch_cnt+1 >= max(max_epoch,1)`: set `done`, go to IDLE.
  - Else clear `err_cnt` and return to RUN.
- `max_epoch` is sampled at `start` into an internal register; later changes have no effect on a running job.
- `busy = 1` in RUN and CHECK.
- Outside RUN, `slp_t_en = 0`. `slp_in`/`slp_train` still show entry `idx`; the values are don't-care to the perceptron.
- `err_cnt` and `epoch_cnt` hold their final values in IDLE until the next `start`.

## Timing
- Reset values: `ld_ready=1`, `busy=0`, `done=0`, `converged=0`, `epoch_cnt=0`, `err_cnt=0`, `slp_t_en=0`. Also `count=0` and `idx=0`; buffer contents are not reset.
- Reset asserted mid-run aborts immediately. The perceptron sees `slp_t_en` drop asynchronously.
- `start` accepted at edge k puts the block in RUN at cycle k+1.
- One epoch of N samples takes N+1 cycles: N RUN cycles and 1 CHECK cycle. A full run of E epochs takes E·(N+1) cycles.
- `done` is visible on the cycle after the final CHECK. `busy` falls on that same cycle.
- Perceptron weight update and error count use the same edge, so there is no pipeline bubble between samples.

## Configuration
- `SLP_SEQ_EARLY_STOP_EN` defined: a CHECK with `err_cnt == 0` ends the run with `converged=1`.
- Undefined: every run executes exactly `max(max_epoch,1)` epochs, and `converged` is tied to 0.

## Test plan
- Reset then load 4 samples with `ld_valid` held high: `count` reaches 4, and `ld_ready` stays 1 → after DEPTH=16 writes, `ld_ready=0` and a 17th write is dropped.
- Start with 4 samples and `max_epoch=3`, perceptron stubbed to always mismatch: `busy` lasts 15 cycles, `slp_t_en` pattern is 1111 0 1111 0 1111 0, final `epoch_cnt=3`, `err_cnt=4`, `done=1`, `converged=0`.
- Early stop enabled, stub matches from epoch 2 on: ends after 2 epochs (10 cycles), `converged=1`, `err_cnt=0`.
- `start` with `count=0` → stays IDLE, `busy=0`. `max_epoch=0` with 2 samples → exactly 1 epoch, 3 cycles.
- Same-cycle events in IDLE: `clr`+`start` → `count=0`, no run. `start`+`ld_valid` with `count=3` → run replays 4 samples.
- Assert `reset_` during RUN at `idx=2` → outputs return to reset values asynchronously. A subsequent `start` is ignored until samples are reloaded, because `count=0`.
